// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT_ACK)
//   DEF_*       : default bus widths used as parameter defaults by the arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = 4;

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per master
//   last_i  : index of the master granted most recently
//   pick_o  : one-hot winner, the first requester at or after last_i+1 (wrapping)
//   valid_o : high when any request is present
module rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NUM_M-1:0] pick_o,
  output logic             valid_o
);

  logic found;

  // Walk the priority order last+1, last+2, ... and take the first requester.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      for (int j = 0; j < NUM_M; j++) begin
        if (!found && req_i[j] && (j == (int'(last_i) + k) % NUM_M)) begin
          pick_o[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM port between NUM_M masters.
// One transaction is in flight at a time; the grant is held from the request
// until the RAM acks or an ack timeout forces completion.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   m_wb_*_i             : packed per-master strobe/we/sel/addr/write data
//   m_wb_data_o          : shared read data, non-zero only alongside an ack
//   m_wb_ack_o/stall_o   : per-master ack and stall
//   s_wb_*_o / s_wb_*_i  : RAM-side Wishbone port
//   grant_o              : one-hot current grant (0 while idle)
//   timeout_o            : one-cycle pulse when an ack timeout fires
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M       = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_M-1:0]        m_wb_stb_i,
  input  logic [NUM_M-1:0]        m_wb_we_i,
  input  logic [NUM_M*SEL_W-1:0]  m_wb_sel_i,
  input  logic [NUM_M*ADDR_W-1:0] m_wb_addr_i,
  input  logic [NUM_M*DATA_W-1:0] m_wb_data_i,
  output logic [DATA_W-1:0]       m_wb_data_o,
  output logic [NUM_M-1:0]        m_wb_ack_o,
  output logic [NUM_M-1:0]        m_wb_stall_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [SEL_W-1:0]        s_wb_sel_o,
  output logic [ADDR_W-1:0]       s_wb_addr_o,
  output logic [DATA_W-1:0]       s_wb_data_o,
  input  logic [DATA_W-1:0]       s_wb_data_i,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_stall_i,
  output logic [NUM_M-1:0]        grant_o,
  output logic                    timeout_o
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_M-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_M-1:0] g_oh;
  logic             g_stb;

  rr_picker #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (m_wb_stb_i),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  // One-hot pick to index; grant index back to one-hot; master-side muxes.
  always_comb begin
    pick_idx    = '0;
    g_oh        = '0;
    g_stb       = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_sel_o  = '0;
    s_wb_addr_o = '0;
    s_wb_data_o = '0;
    for (int j = 0; j < NUM_M; j++) begin
      if (pick[j]) pick_idx = IDX_W'(j);
      if (IDX_W'(j) == gidx_q) begin
        g_oh[j]     = 1'b1;
        g_stb       = m_wb_stb_i[j];
        s_wb_we_o   = m_wb_we_i[j];
        s_wb_sel_o  = m_wb_sel_i[j*SEL_W +: SEL_W];
        s_wb_addr_o = m_wb_addr_i[j*ADDR_W +: ADDR_W];
        s_wb_data_o = m_wb_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    s_wb_stb_o   = 1'b0;
    m_wb_ack_o   = '0;
    m_wb_stall_o = '1;
    m_wb_data_o  = '0;
    grant_o      = '0;
    timeout_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        grant_o      = g_oh;
        s_wb_stb_o   = g_stb;
        m_wb_stall_o = ~g_oh | {NUM_M{s_wb_stall_i}};
        if (!g_stb) begin
          // Master withdrew before acceptance: drop it without an ack and
          // without advancing the round-robin pointer.
          state_d = IDLE;
        end else if (!s_wb_stall_i) begin
          cnt_d = '0;
          if (s_wb_ack_i) begin
            m_wb_ack_o  = g_oh;
            m_wb_data_o = s_wb_data_i;
            last_d      = gidx_q;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        grant_o = g_oh;
        if (s_wb_ack_i) begin
          m_wb_ack_o  = g_oh;
          m_wb_data_o = s_wb_data_i;
          last_d      = gidx_q;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Forced completion: the master gets an ack carrying zero data.
          m_wb_ack_o = g_oh;
          timeout_o  = 1'b1;
          last_d     = gidx_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed testbench for wb_rr_arbiter with a small behavioural RAM slave
// that acks one cycle after acceptance.
module tb_wb_rr_arbiter;

  localparam int NUM_M       = 4;
  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = 4;
  localparam int ACK_TIMEOUT = 16;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_M-1:0]        m_stb, m_we;
  logic [NUM_M*SEL_W-1:0]  m_sel;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]       m_rdata;
  logic [NUM_M-1:0]        m_ack, m_stall;
  logic                    s_stb, s_we;
  logic [SEL_W-1:0]        s_sel;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata, s_rdata;
  logic                    s_ack, s_stall;
  logic [NUM_M-1:0]        grant;
  logic                    timeout;

  wb_rr_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_sel_i(m_sel),
    .m_wb_addr_i(m_addr), .m_wb_data_i(m_wdata),
    .m_wb_data_o(m_rdata), .m_wb_ack_o(m_ack), .m_wb_stall_o(m_stall),
    .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
    .s_wb_addr_o(s_addr), .s_wb_data_o(s_wdata), .s_wb_data_i(s_rdata),
    .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM slave
  logic [DATA_W-1:0] mem [0:2047];
  logic              ack_q   = 1'b0;
  logic [DATA_W-1:0] rdata_q = '0;
  int                n_accept = 0;
  logic              no_ack, spur_ack;

  assign s_ack   = ack_q | spur_ack;
  assign s_rdata = rdata_q;

  always_ff @(posedge clk_i) begin
    ack_q <= 1'b0;
    if (s_stb && !s_stall) begin
      n_accept <= n_accept + 1;
      ack_q    <= !no_ack;
      if (s_we) begin
        for (int k = 0; k < SEL_W; k++)
          if (s_sel[k]) mem[s_addr][k*8 +: 8] <= s_wdata[k*8 +: 8];
      end else begin
        rdata_q <= mem[s_addr];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int g);
    return 64'd1 << g;
  endfunction

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic req(input int i, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    m_we[i]                      = we;
    m_sel[i*SEL_W +: SEL_W]      = '1;
    m_addr[i*ADDR_W +: ADDR_W]   = a;
    m_wdata[i*DATA_W +: DATA_W]  = d;
    m_stb[i]                     = 1'b1;
  endtask

  // Called on a negedge while the arbiter is idle with master g's request up.
  task automatic serve(input int g, input bit drop, input bit chk_d,
                       input logic [DATA_W-1:0] exp_d);
    cyc();
    chk($sformatf("grant_m%0d", g), grant, oh(g));
    chk($sformatf("s_stb_m%0d", g), s_stb, 1);
    cyc();
    chk($sformatf("ack_m%0d", g), m_ack, oh(g));
    if (chk_d) chk($sformatf("rdata_m%0d", g), m_rdata, exp_d);
    if (drop) m_stb[g] = 1'b0;
    cyc();
    chk("idle_grant", grant, 0);
    chk("idle_ack", m_ack, 0);
    chk("idle_data", m_rdata, 0);
  endtask

  int a0;

  initial begin
    rst_i = 1'b1; m_stb = '0; m_we = '0; m_sel = '0; m_addr = '0; m_wdata = '0;
    s_stall = 1'b0; no_ack = 1'b0; spur_ack = 1'b0;
    cyc(); cyc();
    chk("rst_s_stb", s_stb, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_stall", m_stall, 4'hF);
    chk("rst_grant", grant, 0);
    rst_i = 1'b0;
    cyc();

    // Single master write then read-back
    req(1, 1'b1, 11'h004, 32'hAAAA_BBBB);
    #1 chk("t1_no_stb_same_cycle", s_stb, 0);
    cyc();
    chk("t1_grant", grant, oh(1));
    chk("t1_s_stb", s_stb, 1);
    chk("t1_s_addr", s_addr, 11'h004);
    chk("t1_s_we", s_we, 1);
    chk("t1_s_wdata", s_wdata, 32'hAAAA_BBBB);
    chk("t1_stall", m_stall, 4'b1101);
    cyc();
    chk("t1_ack", m_ack, oh(1));
    m_stb[1] = 1'b0;
    cyc();
    chk("t1_ack_gone", m_ack, 0);
    chk("t1_mem", mem[11'h004], 32'hAAAA_BBBB);
    req(1, 1'b0, 11'h004, '0);
    serve(1, 1'b1, 1'b1, 32'hAAAA_BBBB);

    // Simultaneous requests after reset: order 0, 2, 3
    rst_i = 1'b1; cyc(); rst_i = 1'b0; cyc();
    req(0, 1'b1, 11'h020, 32'h0000_0000);
    req(2, 1'b1, 11'h024, 32'h2222_2222);
    req(3, 1'b1, 11'h028, 32'h3333_3333);
    serve(0, 1'b1, 1'b0, '0);
    serve(2, 1'b1, 1'b0, '0);
    serve(3, 1'b1, 1'b0, '0);

    // Fairness: master 0 continuous, master 1 once
    req(0, 1'b1, 11'h010, 32'h1);
    req(1, 1'b1, 11'h014, 32'h2);
    serve(0, 1'b0, 1'b0, '0);
    serve(1, 1'b1, 1'b0, '0);
    serve(0, 1'b1, 1'b0, '0);

    // Spurious ack while idle is ignored
    spur_ack = 1'b1;
    #1 chk("spur_idle_ack", m_ack, 0);
    spur_ack = 1'b0;

    // Ack in the same cycle as acceptance; the late slave ack is then ignored
    req(0, 1'b0, 11'h004, '0);
    cyc();
    chk("sc_grant", grant, oh(0));
    spur_ack = 1'b1;
    #1 chk("sc_ack", m_ack, oh(0));
    chk("sc_data", m_rdata, 32'hAAAA_BBBB);
    cyc();
    spur_ack = 1'b0;
    m_stb[0] = 1'b0;
    #1 chk("sc_late_ack_ignored", m_ack, 0);
    chk("sc_idle_grant", grant, 0);

    // RAM stall for 3 cycles on master 2 write
    a0 = n_accept;
    s_stall = 1'b1;
    req(2, 1'b1, 11'h408, 32'h1234_5678);
    cyc();
    chk("st_grant", grant, oh(2));
    chk("st_stall_c1", m_stall, 4'hF);
    spur_ack = 1'b1;
    #1 chk("st_spur_ack", m_ack, 0);
    spur_ack = 1'b0;
    cyc();
    chk("st_stall_c2", m_stall, 4'hF);
    cyc();
    chk("st_stall_c3", m_stall, 4'hF);
    chk("st_no_accept", n_accept, a0);
    s_stall = 1'b0;
    #1 chk("st_stall_release", m_stall, 4'b1011);
    cyc();
    chk("st_ack", m_ack, oh(2));
    chk("st_one_accept", n_accept, a0 + 1);
    chk("st_mem", mem[11'h408], 32'h1234_5678);
    m_stb[2] = 1'b0;
    cyc();
    chk("st_idle", grant, 0);
    req(2, 1'b0, 11'h408, '0);
    serve(2, 1'b1, 1'b1, 32'h1234_5678);

    // Ack timeout on master 3, then master 1 is granted
    no_ack = 1'b1;
    req(3, 1'b0, 11'h004, '0);
    req(1, 1'b0, 11'h408, '0);
    cyc();
    chk("to_grant", grant, oh(3));
    cyc();
    for (int k = 0; k < ACK_TIMEOUT - 1; k++) begin
      chk($sformatf("to_wait_ack_c%0d", k), m_ack, 0);
      chk($sformatf("to_wait_pulse_c%0d", k), timeout, 0);
      cyc();
    end
    chk("to_ack", m_ack, oh(3));
    chk("to_pulse", timeout, 1);
    chk("to_data_zero", m_rdata, 0);
    m_stb[3] = 1'b0;
    no_ack = 1'b0;
    cyc();
    chk("to_pulse_once", timeout, 0);
    chk("to_ack_once", m_ack, 0);
    serve(1, 1'b1, 1'b1, 32'h1234_5678);

    // Reset during WAIT_ACK
    no_ack = 1'b1;
    req(2, 1'b0, 11'h408, '0);
    cyc();
    cyc();
    chk("rm_wait_grant", grant, oh(2));
    req(0, 1'b0, 11'h004, '0);
    rst_i = 1'b1;
    cyc();
    chk("rm_grant", grant, 0);
    chk("rm_ack", m_ack, 0);
    chk("rm_s_stb", s_stb, 0);
    chk("rm_stall", m_stall, 4'hF);
    rst_i = 1'b0;
    no_ack = 1'b0;
    cyc();
    chk("rm_first_m0", grant, oh(0));
    cyc();
    chk("rm_m0_ack", m_ack, oh(0));
    chk("rm_m0_data", m_rdata, 32'hAAAA_BBBB);
    m_stb[0] = 1'b0;
    cyc();
    serve(2, 1'b1, 1'b1, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
